// File: rtl/reg_snapshot_streamer.sv
// Captures a bank of live registers plus status flags on request and streams them out
// as one header word followed by the register words over a valid/ready handshake.
module reg_snapshot_streamer #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned FLAG_W   = 2,
    localparam int unsigned IDX_W   = $clog2(NUM_REGS + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REGS*DATA_W-1:0]   reg_flat,
    input  logic [FLAG_W-1:0]            flags_in,
    input  logic                         snap_req,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [IDX_W-1:0]             out_idx,
    output logic                         out_last,
    output logic                         busy,
    output logic [15:0]                  snap_count,
    output logic [7:0]                   drop_count
);

    typedef enum logic {
        StIdle,
        StSend
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_shadow [NUM_REGS];
    logic [DATA_W-1:0]   r_data;
    logic [IDX_W-1:0]    r_idx;
    logic                r_last;
    logic [15:0]         r_snap;
    logic [7:0]          r_drop;

    logic [DATA_W-1:0]   w_hdr;
    logic [DATA_W-1:0]   w_word;
    logic [IDX_W-1:0]    w_idx_inc;
    logic                w_xfer;
    logic                w_last_xfer;
    logic                w_capture;

    always_comb begin
        w_hdr                = '0;
        w_hdr[FLAG_W-1:0]    = flags_in;
    end

    // Word following the current index comes from shadow register r_idx.
    always_comb begin
        w_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_word = r_shadow[i];
            end
        end
    end

    assign w_idx_inc   = r_idx + IDX_W'(1);
    assign w_xfer      = (r_state == StSend) && out_ready;
    assign w_last_xfer = w_xfer && (r_idx == IDX_W'(NUM_REGS));
    // A request landing on the last-word handshake chains straight into a new frame.
    assign w_capture   = snap_req && ((r_state == StIdle) || w_last_xfer);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_data  <= '0;
            r_idx   <= '0;
            r_last  <= 1'b0;
            r_snap  <= '0;
            r_drop  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            if (w_capture) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    r_shadow[i] <= reg_flat[i*DATA_W +: DATA_W];
                end
                r_state <= StSend;
                r_idx   <= '0;
                r_data  <= w_hdr;
                r_last  <= 1'b0;
            end else if (w_last_xfer) begin
                r_state <= StIdle;
                r_idx   <= '0;
                r_data  <= '0;
                r_last  <= 1'b0;
            end else if (w_xfer) begin
                r_idx   <= w_idx_inc;
                r_data  <= w_word;
                r_last  <= (w_idx_inc == IDX_W'(NUM_REGS));
            end

            if (w_last_xfer) begin
                r_snap <= r_snap + 16'd1;
            end

            if (snap_req && (r_state == StSend) && !w_last_xfer && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end
        end
    end

    assign out_valid  = (r_state == StSend);
    assign busy       = (r_state == StSend);
    assign out_data   = r_data;
    assign out_idx    = r_idx;
    assign out_last   = r_last;
    assign snap_count = r_snap;
    assign drop_count = r_drop;

endmodule

// File: tb/tb_reg_snapshot_streamer.sv
// Bench for reg_snapshot_streamer: frame-level model checked every cycle, plus directed
// scenarios with literal expectations on a default and a small (3 x 8-bit) instance.
module tb_reg_snapshot_streamer;

    localparam int N = 8;
    localparam int W = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N*W-1:0]  reg_flat = '0;
    logic [1:0]      flags_in = '0;
    logic            snap_req = 1'b0;
    logic            out_ready = 1'b1;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic [3:0]      out_idx;
    logic            out_last;
    logic            busy;
    logic [15:0]     snap_count;
    logic [7:0]      drop_count;

    logic [23:0]     reg_flat3 = '0;
    logic [1:0]      flags3 = '0;
    logic            snap3 = 1'b0;
    logic            ready3 = 1'b1;
    logic            valid3;
    logic [7:0]      data3;
    logic [1:0]      idx3;
    logic            last3;
    logic            busy3;
    logic [15:0]     sc3;
    logic [7:0]      dc3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_snapshot_streamer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .reg_flat   (reg_flat),
        .flags_in   (flags_in),
        .snap_req   (snap_req),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .busy       (busy),
        .snap_count (snap_count),
        .drop_count (drop_count)
    );

    reg_snapshot_streamer #(.NUM_REGS(3), .DATA_W(8), .FLAG_W(2)) dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .reg_flat   (reg_flat3),
        .flags_in   (flags3),
        .snap_req   (snap3),
        .out_valid  (valid3),
        .out_ready  (ready3),
        .out_data   (data3),
        .out_idx    (idx3),
        .out_last   (last3),
        .busy       (busy3),
        .snap_count (sc3),
        .drop_count (dc3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: a captured frame is a list of words, consumed one per handshake.
    bit           m_busy = 1'b0;
    int           m_pos = 0;
    int           m_snap = 0;
    int           m_drop = 0;
    logic [15:0]  m_frame [N+1];

    typedef struct {
        int          idx;
        logic [15:0] data;
        bit          last;
    } word_t;
    word_t xq[$];

    task automatic model_capture();
        m_frame[0] = {14'b0, flags_in};
        for (int k = 1; k <= N; k++) m_frame[k] = reg_flat[(k-1)*W +: W];
        m_busy = 1'b1;
        m_pos  = 0;
    endtask

    task automatic model_step();
        bit done;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_pos  = 0;
            m_snap = 0;
            m_drop = 0;
        end else if (!m_busy) begin
            if (snap_req) model_capture();
        end else begin
            done = out_ready && (m_pos == N);
            if (snap_req && !done && m_drop < 255) m_drop++;
            if (done) begin
                m_snap = (m_snap + 1) % 65536;
                if (snap_req) model_capture();
                else m_busy = 1'b0;
            end else if (out_ready) begin
                m_pos++;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (out_valid && out_ready) xq.push_back('{int'(out_idx), out_data, out_last});
            model_step();
            #1;
            chk("cyc_valid", out_valid, m_busy);
            chk("cyc_busy", busy, m_busy);
            chk("cyc_data", out_data, m_busy ? m_frame[m_pos] : 16'h0);
            chk("cyc_idx", out_idx, m_busy ? m_pos : 0);
            chk("cyc_last", out_last, m_busy && (m_pos == N));
            chk("cyc_snap", snap_count, m_snap);
            chk("cyc_drop", drop_count, m_drop);
        end
    end

    task automatic set_regs(input logic [15:0] base);
        for (int i = 0; i < N; i++) reg_flat[i*W +: W] = base + 16'(i);
    endtask

    task automatic pulse();
        @(negedge clk); snap_req = 1'b1;
        @(negedge clk); snap_req = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle_timeout"}, busy, 1'b0);
    endtask

    task automatic wait_idx(input string tag, input int target);
        int n = 0;
        while (out_idx != 4'(target) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_reach_idx"}, out_idx, target);
    endtask

    task automatic check_frame(input string tag, input logic [15:0] hdr, input logic [15:0] base);
        chk({tag, "_nwords"}, xq.size(), N + 1);
        for (int k = 0; k < xq.size() && k <= N; k++) begin
            chk({tag, "_word"}, xq[k].data, (k == 0) ? hdr : base + 16'(k - 1));
            chk({tag, "_widx"}, xq[k].idx, k);
            chk({tag, "_wlast"}, xq[k].last, k == N);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int nvalid;

        repeat (3) @(negedge clk);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_snap", snap_count, 16'h0);
        rst_n = 1'b1;

        // Basic frame
        xq.delete();
        set_regs(16'h1000);
        flags_in = 2'b10;
        pulse();
        chk("t1_latency_valid", out_valid, 1'b1);
        chk("t1_header", out_data, 16'h0002);
        wait_idle("t1");
        check_frame("t1", 16'h0002, 16'h1000);
        chk("t1_snap", snap_count, 16'd1);

        // Small instance: 4-word frames, last on idx 3
        reg_flat3 = {8'hA2, 8'hA1, 8'hA0};
        flags3 = 2'b11;
        @(negedge clk); snap3 = 1'b1;
        @(negedge clk); snap3 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            logic [7:0] e;
            e = (k == 0) ? 8'h03 : 8'hA0 + 8'(k - 1);
            chk("s3_valid", valid3, 1'b1);
            chk("s3_idx", idx3, k);
            chk("s3_data", data3, e);
            chk("s3_last", last3, k == 3);
            @(negedge clk);
        end
        chk("s3_done", valid3, 1'b0);
        chk("s3_snap", sc3, 16'd1);

        // Backpressure toggling with live inputs scrambled after capture
        xq.delete();
        set_regs(16'h2000);
        flags_in = 2'b01;
        out_ready = 1'b0;
        pulse();
        nvalid = 0;
        for (int c = 0; c < 60; c++) begin
            if (!out_valid) break;
            nvalid++;
            out_ready = c[0];
            reg_flat = {$urandom, $urandom, $urandom, $urandom};
            flags_in = 2'($urandom);
            @(negedge clk);
        end
        out_ready = 1'b1;
        chk("t2_valid_cycles", nvalid, 18);
        check_frame("t2", 16'h0001, 16'h2000);

        // Requests during a stalled frame are dropped with saturation
        xq.delete();
        set_regs(16'h3000);
        flags_in = 2'b11;
        out_ready = 1'b0;
        pulse();
        for (int i = 0; i < 300; i++) begin
            snap_req = 1'b1;
            @(negedge clk);
            snap_req = 1'b0;
            @(negedge clk);
        end
        chk("t3_drop_sat", drop_count, 8'hFF);
        out_ready = 1'b1;
        wait_idle("t3");
        check_frame("t3", 16'h0003, 16'h3000);
        chk("t3_snap", snap_count, 16'd3);

        // Back-to-back frame on the last-word handshake
        set_regs(16'h4000);
        flags_in = 2'b00;
        pulse();
        wait_idx("t4", 8);
        snap_req = 1'b1;
        set_regs(16'h5000);
        flags_in = 2'b01;
        @(negedge clk);
        snap_req = 1'b0;
        chk("t4_chain_valid", out_valid, 1'b1);
        chk("t4_chain_idx", out_idx, 4'd0);
        chk("t4_chain_hdr", out_data, 16'h0001);
        chk("t4_chain_snap", snap_count, 16'd4);
        xq.delete();
        wait_idle("t4");
        check_frame("t4", 16'h0001, 16'h5000);
        chk("t4_snap", snap_count, 16'd5);

        // Reset mid-frame, with a request held during reset
        set_regs(16'h6000);
        flags_in = 2'b10;
        pulse();
        wait_idx("t5", 4);
        rst_n = 1'b0;
        snap_req = 1'b1;
        @(negedge clk);
        chk("t5_rst_valid", out_valid, 1'b0);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_data", out_data, 16'h0);
        chk("t5_rst_idx", out_idx, 4'd0);
        chk("t5_rst_last", out_last, 1'b0);
        chk("t5_rst_snap", snap_count, 16'h0);
        chk("t5_rst_drop", drop_count, 8'h0);
        rst_n = 1'b1;
        snap_req = 1'b0;
        @(negedge clk);
        chk("t5_req_ignored", out_valid, 1'b0);
        xq.delete();
        pulse();
        wait_idle("t5");
        check_frame("t5", 16'h0002, 16'h6000);
        chk("t5_snap", snap_count, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
